// File: rtl/dds_wave_gen_pkg.sv
// Shared constants for the DDS waveform generator: waveform codes,
// DAC midscale and the default frequency-word increment.
package dds_pkg;

    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_SAW    = 2'd3;

    localparam logic [7:0] DAC_MID = 8'd128;

    // Roughly 1 kHz per unit of sel with a 50 MHz clock and a 32-bit accumulator
    localparam logic [31:0] STEP_BASE_DEFAULT = 32'd85_899;

endpackage

// File: rtl/dds_wave_gen_sine_qlut.sv
// Quarter-wave sine ROM: entry k = round(127 * sin((k + 0.5) * pi / 128)).
// Output is registered so the table read forms the second pipeline stage.
module sine_qlut (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] idx,
    output logic [6:0] level
);

    logic [6:0] rom_val;

    always_comb begin
        rom_val = 7'd0;
        case (idx)
            6'd0:  rom_val = 7'd2;   6'd1:  rom_val = 7'd5;   6'd2:  rom_val = 7'd8;   6'd3:  rom_val = 7'd11;
            6'd4:  rom_val = 7'd14;  6'd5:  rom_val = 7'd17;  6'd6:  rom_val = 7'd20;  6'd7:  rom_val = 7'd23;
            6'd8:  rom_val = 7'd26;  6'd9:  rom_val = 7'd29;  6'd10: rom_val = 7'd32;  6'd11: rom_val = 7'd35;
            6'd12: rom_val = 7'd38;  6'd13: rom_val = 7'd41;  6'd14: rom_val = 7'd44;  6'd15: rom_val = 7'd47;
            6'd16: rom_val = 7'd50;  6'd17: rom_val = 7'd53;  6'd18: rom_val = 7'd56;  6'd19: rom_val = 7'd58;
            6'd20: rom_val = 7'd61;  6'd21: rom_val = 7'd64;  6'd22: rom_val = 7'd67;  6'd23: rom_val = 7'd69;
            6'd24: rom_val = 7'd72;  6'd25: rom_val = 7'd74;  6'd26: rom_val = 7'd77;  6'd27: rom_val = 7'd79;
            6'd28: rom_val = 7'd82;  6'd29: rom_val = 7'd84;  6'd30: rom_val = 7'd86;  6'd31: rom_val = 7'd89;
            6'd32: rom_val = 7'd91;  6'd33: rom_val = 7'd93;  6'd34: rom_val = 7'd95;  6'd35: rom_val = 7'd97;
            6'd36: rom_val = 7'd99;  6'd37: rom_val = 7'd101; 6'd38: rom_val = 7'd103; 6'd39: rom_val = 7'd105;
            6'd40: rom_val = 7'd106; 6'd41: rom_val = 7'd108; 6'd42: rom_val = 7'd110; 6'd43: rom_val = 7'd111;
            6'd44: rom_val = 7'd113; 6'd45: rom_val = 7'd114; 6'd46: rom_val = 7'd115; 6'd47: rom_val = 7'd117;
            6'd48: rom_val = 7'd118; 6'd49: rom_val = 7'd119; 6'd50: rom_val = 7'd120; 6'd51: rom_val = 7'd121;
            6'd52: rom_val = 7'd122; 6'd53: rom_val = 7'd123; 6'd54: rom_val = 7'd124; 6'd55: rom_val = 7'd124;
            6'd56: rom_val = 7'd125; 6'd57: rom_val = 7'd125; 6'd58: rom_val = 7'd126; 6'd59: rom_val = 7'd126;
            6'd60: rom_val = 7'd127; 6'd61: rom_val = 7'd127; 6'd62: rom_val = 7'd127; 6'd63: rom_val = 7'd127;
            default: rom_val = 7'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 7'd0;
        end else if (en) begin
            level <= rom_val;
        end
    end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator with wrap-deferred frequency
// updates feeding a two-stage shaping pipeline that drives an 8-bit DAC.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int          PHASE_W   = 32,
    parameter logic [31:0] STEP_BASE = STEP_BASE_DEFAULT,
    parameter int          DATA_W    = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [4:0]        sel,
    input  logic              sel_flag,
    input  logic [1:0]        wave_type,
    input  logic              enable,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic              phase_wrap,
    output logic              update_pending
);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] active_fw;
    logic [PHASE_W-1:0] pending_fw;
    logic [PHASE_W-1:0] req_fw;
    logic [PHASE_W:0]   sum;
    logic               carry;

    assign req_fw = PHASE_W'(STEP_BASE * 32'(sel));
    assign sum    = {1'b0, phase} + {1'b0, active_fw};
    assign carry  = enable & sum[PHASE_W];

    // A request arriving on the wrap edge bypasses the pending word entirely;
    // a stopped accumulator never wraps, so it takes the pending word at once.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            phase          <= '0;
            active_fw      <= '0;
            pending_fw     <= '0;
            update_pending <= 1'b0;
            phase_wrap     <= 1'b0;
        end else begin
            phase_wrap <= carry;
            if (enable) begin
                phase <= sum[PHASE_W-1:0];
            end
            if (carry && sel_flag) begin
                active_fw      <= req_fw;
                pending_fw     <= req_fw;
                update_pending <= 1'b0;
            end else if (carry && update_pending) begin
                active_fw      <= pending_fw;
                update_pending <= 1'b0;
            end else begin
                if (enable && update_pending && (active_fw == '0)) begin
                    active_fw      <= pending_fw;
                    update_pending <= 1'b0;
                end
                if (sel_flag) begin
                    pending_fw     <= req_fw;
                    update_pending <= 1'b1;
                end
            end
        end
    end

    logic       s1_valid;
    logic [7:0] s1_a;
    logic [1:0] s1_type;
    logic       s2_valid;
    logic [7:0] s2_a;
    logic [1:0] s2_type;
    logic [6:0] sine_level;
    logic [5:0] lut_idx;
    logic [7:0] shaped;

    // Stage 2 only loads on a valid sample, which makes dac_data hold when idle.
    // Its reset values (sawtooth at midscale) put 128 on the DAC out of reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_valid <= 1'b0;
            s1_a     <= 8'd0;
            s1_type  <= WAVE_SAW;
            s2_valid <= 1'b0;
            s2_a     <= DAC_MID;
            s2_type  <= WAVE_SAW;
        end else begin
            s1_valid <= enable;
            s1_a     <= phase[PHASE_W-1 -: 8];
            s1_type  <= wave_type;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_a    <= s1_a;
                s2_type <= s1_type;
            end
        end
    end

    // Quadrants 1 and 3 read the quarter table backwards
    assign lut_idx = s1_a[6] ? ~s1_a[5:0] : s1_a[5:0];

    sine_qlut u_sine_qlut (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .en    (s1_valid),
        .idx   (lut_idx),
        .level (sine_level)
    );

    always_comb begin
        shaped = s2_a;
        case (s2_type)
            WAVE_SINE:   shaped = s2_a[7] ? (8'd127 - {1'b0, sine_level}) : (DAC_MID + {1'b0, sine_level});
            WAVE_SQUARE: shaped = s2_a[7] ? 8'h00 : 8'hFF;
            WAVE_TRI:    shaped = s2_a[7] ? ~{s2_a[6:0], 1'b0} : {s2_a[6:0], 1'b0};
            default:     shaped = s2_a;
        endcase
    end

    assign dac_data  = shaped;
    assign dac_valid = s2_valid;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: a behavioural model queues expected
// samples and control flags, and an independent monitor checks the DUT.
module tb_dds_wave_gen;
    import dds_pkg::*;

    localparam logic [31:0] STEP = 32'h0100_0000;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [4:0] sel;
    logic       sel_flag;
    logic [1:0] wave_type;
    logic       enable;
    logic [7:0] dac_data;
    logic       dac_valid;
    logic       phase_wrap;
    logic       update_pending;

    dds_wave_gen #(.PHASE_W(32), .STEP_BASE(STEP), .DATA_W(8)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .sel            (sel),
        .sel_flag       (sel_flag),
        .wave_type      (wave_type),
        .enable         (enable),
        .dac_data       (dac_data),
        .dac_valid      (dac_valid),
        .phase_wrap     (phase_wrap),
        .update_pending (update_pending)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_phase;
    logic [31:0] m_active;
    logic [31:0] m_pending;
    bit          m_upd;
    bit          m_prev_en;
    logic [7:0]  last_sample;
    bit          monitor_on = 1'b0;
    logic [7:0]  exp_q[$];
    logic [2:0]  ctrl_q[$];

    bit          r_flag;
    logic [4:0]  r_sel;
    bit          r_en;
    logic [1:0]  r_wt;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportMissing(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: actual empty queue, expected an entry at %0t", name, $time);
    endtask

    // Waveform definitions written directly from the sample formulas
    function automatic logic [7:0] shape(input logic [7:0] a, input logic [1:0] wt);
        int  q;
        int  i;
        int  l;
        real x;
        case (wt)
            WAVE_SINE: begin
                q = int'(a) / 64;
                i = int'(a) % 64;
                if (q % 2 == 1) i = 63 - i;
                x = 127.0 * $sin((real'(i) + 0.5) * 3.14159265358979 / 128.0);
                l = $rtoi(x + 0.5);
                return (q < 2) ? 8'(128 + l) : 8'(127 - l);
            end
            WAVE_SQUARE: return (a >= 8'd128) ? 8'd0 : 8'd255;
            WAVE_TRI:    return (a < 8'd128) ? 8'(2 * int'(a)) : 8'(255 - 2 * (int'(a) - 128));
            default:     return a;
        endcase
    endfunction

    function automatic bit modelWrapsNext();
        longint unsigned s;
        s = longint'(m_phase) + longint'(m_active);
        return s > 64'hFFFF_FFFF;
    endfunction

    // One clock of the reference model, using the inputs about to be sampled
    task automatic modelStep();
        longint unsigned s;
        bit              carry;
        logic [31:0]     w;
        if (enable) exp_q.push_back(shape(m_phase[31:24], wave_type));
        s     = longint'(m_phase) + longint'(m_active);
        carry = enable && (s > 64'hFFFF_FFFF);
        w     = 32'(longint'(STEP) * longint'(sel));
        if (carry && sel_flag) begin
            m_active  = w;
            m_pending = w;
            m_upd     = 1'b0;
        end else if (carry && m_upd) begin
            m_active = m_pending;
            m_upd    = 1'b0;
        end else begin
            if (enable && m_upd && m_active == 32'd0) begin
                m_active = m_pending;
                m_upd    = 1'b0;
            end
            if (sel_flag) begin
                m_pending = w;
                m_upd     = 1'b1;
            end
        end
        if (enable) m_phase = 32'(s);
        ctrl_q.push_back({carry, m_upd, m_prev_en});
        m_prev_en = enable;
    endtask

    task automatic applyStimulus(input bit flag, input logic [4:0] s, input bit en, input logic [1:0] wt);
        @(negedge sys_clk);
        sel_flag   = flag;
        sel        = s;
        enable     = en;
        wave_type  = wt;
        monitor_on = 1'b1;
        modelStep();
    endtask

    task automatic doReset();
        @(negedge sys_clk);
        #2;
        sys_rst    = 1'b1;
        sel_flag   = 1'b0;
        enable     = 1'b0;
        monitor_on = 1'b0;
        #1;
        checkOutput("rst_dac_data", dac_data, 32'd128);
        checkOutput("rst_dac_valid", dac_valid, 32'd0);
        checkOutput("rst_phase_wrap", phase_wrap, 32'd0);
        checkOutput("rst_update_pending", update_pending, 32'd0);
        exp_q.delete();
        ctrl_q.delete();
        m_phase     = 32'd0;
        m_active    = 32'd0;
        m_pending   = 32'd0;
        m_upd       = 1'b0;
        m_prev_en   = 1'b0;
        last_sample = DAC_MID;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a cycle of output
    initial begin
        logic [2:0] c;
        logic [7:0] e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (monitor_on) begin
                if (ctrl_q.size() == 0) begin
                    reportMissing("ctrl_queue");
                end else begin
                    c = ctrl_q.pop_front();
                    checkOutput("phase_wrap", phase_wrap, c[2]);
                    checkOutput("update_pending", update_pending, c[1]);
                    checkOutput("dac_valid", dac_valid, c[0]);
                end
                if (dac_valid) begin
                    if (exp_q.size() == 0) begin
                        reportMissing("sample_queue");
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("dac_sample", dac_data, e);
                        last_sample = e;
                    end
                end else begin
                    checkOutput("dac_hold", dac_data, last_sample);
                end
            end
        end
    end

    initial begin
        int guard;
        sys_rst   = 1'b1;
        sel       = 5'd0;
        sel_flag  = 1'b0;
        enable    = 1'b0;
        wave_type = WAVE_SAW;
        doReset();

        // Sawtooth at sel = 1: full ramp and wrap
        applyStimulus(1'b1, 5'd1, 1'b1, WAVE_SAW);
        repeat (299) applyStimulus(1'b0, 5'd1, 1'b1, WAVE_SAW);

        // Request sel = 2 at a = 100; it must wait for the wrap
        guard = 0;
        while (m_phase[31:24] != 8'd100 && guard < 300) begin
            applyStimulus(1'b0, 5'd1, 1'b1, WAVE_SAW);
            guard++;
        end
        checkOutput("reach_a100", guard < 300, 1);
        applyStimulus(1'b1, 5'd2, 1'b1, WAVE_SAW);
        repeat (300) applyStimulus(1'b0, 5'd2, 1'b1, WAVE_SAW);

        // sel = 2 pending, then sel = 3 in the exact carry-out cycle
        applyStimulus(1'b1, 5'd2, 1'b1, WAVE_SAW);
        guard = 0;
        while (!modelWrapsNext() && guard < 300) begin
            applyStimulus(1'b0, 5'd2, 1'b1, WAVE_SAW);
            guard++;
        end
        checkOutput("reach_wrap", guard < 300, 1);
        applyStimulus(1'b1, 5'd3, 1'b1, WAVE_SAW);
        repeat (100) applyStimulus(1'b0, 5'd3, 1'b1, WAVE_SAW);

        // Sine at sel = 1 across every quadrant
        applyStimulus(1'b1, 5'd1, 1'b1, WAVE_SINE);
        repeat (400) applyStimulus(1'b0, 5'd1, 1'b1, WAVE_SINE);

        // Freeze for 10 cycles mid-period, then resume
        repeat (10) applyStimulus(1'b0, 5'd1, 1'b0, WAVE_SINE);
        repeat (20) applyStimulus(1'b0, 5'd1, 1'b1, WAVE_SINE);

        // Randomized strobes, enables and waveform changes
        r_wt = WAVE_TRI;
        for (int n = 0; n < 3000; n++) begin
            r_flag = ($urandom_range(0, 39) == 0);
            r_sel  = 5'($urandom_range(0, 31));
            r_en   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) r_wt = 2'($urandom_range(0, 3));
            applyStimulus(r_flag, r_sel, r_en, r_wt);
        end

        // Run, then stop with sel = 0 at the next wrap
        applyStimulus(1'b1, 5'd5, 1'b1, WAVE_SQUARE);
        repeat (60) applyStimulus(1'b0, 5'd5, 1'b1, WAVE_SQUARE);
        applyStimulus(1'b1, 5'd0, 1'b1, WAVE_SAW);
        repeat (300) applyStimulus(1'b0, 5'd0, 1'b1, WAVE_SAW);

        // Restart from stopped, leave a request pending, then reset mid-period
        applyStimulus(1'b1, 5'd7, 1'b1, WAVE_TRI);
        repeat (30) applyStimulus(1'b0, 5'd7, 1'b1, WAVE_TRI);
        applyStimulus(1'b1, 5'd9, 1'b1, WAVE_TRI);
        repeat (3) applyStimulus(1'b0, 5'd9, 1'b1, WAVE_TRI);
        doReset();

        applyStimulus(1'b1, 5'd4, 1'b1, WAVE_SINE);
        repeat (80) applyStimulus(1'b0, 5'd4, 1'b1, WAVE_SINE);
        repeat (4) applyStimulus(1'b0, 5'd4, 1'b0, WAVE_SINE);
        @(negedge sys_clk);
        monitor_on = 1'b0;
        checkOutput("samples_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
